// File: rtl/output_drain.sv
// -----------------------------------------------------------------------------
// output_drain
//
// Read-side engine that empties the accelerator output buffer once a layer has
// finished. A start command latches a base address and a word count. The block
// then walks that contiguous address range on the output-buffer SRAM port,
// issuing one read per word. Each returned word goes into a small capture FIFO,
// and the FIFO head is offered on a valid/ready stream toward the DMA side.
//
// Ports
//   CLK, RESET           clock (rising edge) and asynchronous active-high reset
//   start                launch command, only looked at while idle
//   base_addr, length    first word address and word count (length 0 is legal)
//   busy                 high while a transfer is in progress
//   done                 one-cycle pulse after the final stream handshake
//   ob_cen/wen/ren       SRAM chip enable / write enable / retention (active-low)
//   ob_addr              SRAM address
//   ob_data              SRAM read data, valid the cycle after ob_cen is low
//   m_valid/m_ready      output stream handshake
//   m_data               output stream payload (FIFO head)
//
// FIFO_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module output_drain #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              ob_cen,
  output logic              ob_wen,
  output logic              ob_ren,
  output logic [ADDR_W-1:0] ob_addr,
  input  logic [DATA_W-1:0] ob_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Outstanding words (occ + inflight) need one more bit than occ alone.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                             state_q,    state_d;
  logic [ADDR_W-1:0]                  addr_q,     addr_d;     // next read address
  logic [ADDR_W-1:0]                  rem_q,      rem_d;      // reads left to issue
  logic [ADDR_W-1:0]                  out_rem_q,  out_rem_d;  // words left to hand off
  logic                               inflight_q, inflight_d; // read issued last cycle
  logic                               done_q,     done_d;
  logic [CNT_W-1:0]                   occ_q,      occ_d;
  logic [PTR_W-1:0]                   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]                   rd_ptr_q,   rd_ptr_d;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]  mem_q,      mem_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   outstanding;

  // Issue depends only on registered state. This keeps m_ready out of every
  // SRAM-side path, and a slot freed by a pop is used one cycle later.
  assign outstanding = (CNT_W+1)'(occ_q) + (CNT_W+1)'(inflight_q);
  assign issue       = (state_q == ST_READ) && (rem_q != '0) &&
                       (outstanding < DEPTH_C);

  // Synchronous-read SRAM: data for last cycle's issue is on ob_data now.
  assign push    = inflight_q;
  assign m_valid = (occ_q != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = mem_q[rd_ptr_q];

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign ob_cen  = ~issue;
  assign ob_wen  = 1'b1;
  assign ob_ren  = 1'b1;
  assign ob_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_rem_d  = out_rem_q;
    inflight_d = issue;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            // Nothing to move, so acknowledge immediately without leaving idle.
            done_d = 1'b1;
          end else begin
            state_d   = ST_READ;
            addr_d    = base_addr;
            rem_d     = length;
            out_rem_d = length;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Count handoffs. The transfer ends on the handshake of the last word.
    // That word can only leave after its read was issued, so in practice this
    // fires in DRAIN. Testing "not idle" keeps the logic simple.
    if (pop && (state_q != ST_IDLE)) begin
      out_rem_d = out_rem_q - ADDR_W'(1);
      if (out_rem_q == ADDR_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------------
  // Under the issue rule occ + inflight never exceeds FIFO_DEPTH, so a push
  // always has a free slot and no full check is needed here.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = ob_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Reset clears the FIFO storage as well, so m_data reads 0 out of reset and
  // nothing from an aborted transfer can leak into the next one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      out_rem_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      out_rem_q  <= out_rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_output_drain.sv
// Testbench for output_drain. A synchronous-read SRAM model returns the
// zero-extended address as data. Expected stream words are queued whenever a
// command is launched, and they are checked in order as each handshake occurs.
module tb_output_drain;
  localparam int AW = 17;
  localparam int DW = 512;
  localparam int FD = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          busy, done, ob_cen, ob_wen, ob_ren, m_valid, m_ready;
  logic [AW-1:0] ob_addr;
  logic [DW-1:0] ob_data = '0;
  logic [DW-1:0] m_data;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  output_drain #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .ob_cen(ob_cen),
    .ob_wen(ob_wen), .ob_ren(ob_ren), .ob_addr(ob_addr), .ob_data(ob_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 CLK = ~CLK;

  // SRAM model: Q is updated on the edge that ends the enabled cycle.
  always @(posedge CLK) if (!ob_cen) ob_data <= DW'(ob_addr);

  // Scoreboard and static pin checks, sampled mid-cycle.
  always @(negedge CLK) begin
    tests++;
    if (ob_wen !== 1'b1 || ob_ren !== 1'b1) begin
      fails++;
      $display("FAIL sram_static wen=%b ren=%b required 1/1", ob_wen, ob_ren);
    end
    if (RESET === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected got %h with empty scoreboard", m_data[31:0]);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          fails++;
          $display("FAIL sb_data got %h required %h", m_data[31:0], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(DW'(a));
      a = a + AW'(1);
    end
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n);
    start = 1'b1; base_addr = b; length = n;
    push_exp(b, n);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start = 1'($urandom); base_addr = AW'($urandom); length = AW'($urandom);
      m_ready = 1'($urandom);
      @(negedge CLK);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || ob_cen !== 1'b1 || ob_addr !== '0 ||
          m_valid !== 1'b0 || m_data !== '0) begin
        fails++;
        $display("FAIL reset_vals busy=%b done=%b cen=%b addr=%h valid=%b data=%h required 0/0/1/0/0/0",
                 busy, done, ob_cen, ob_addr, m_valid, m_data[31:0]);
      end
      next_cycle();
    end
    start = 1'b0; m_ready = 1'b1;
    RESET = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic e_cen, e_valid, e_done, e_busy;
      if (c == 0) launch(AW'(17'h10), AW'(4));
      else start = 1'b0;
      @(negedge CLK);
      e_cen = !(c >= 1 && c <= 4); e_valid = (c >= 3 && c <= 6);
      e_done = (c == 7); e_busy = (c >= 1 && c <= 6);
      tests++;
      if (ob_cen !== e_cen || m_valid !== e_valid || done !== e_done || busy !== e_busy) begin
        fails++;
        $display("FAIL basic_ctl c=%0d cen=%b valid=%b done=%b busy=%b required %b/%b/%b/%b",
                 c, ob_cen, m_valid, done, busy, e_cen, e_valid, e_done, e_busy);
      end
      if (!e_cen) begin
        tests++;
        if (ob_addr !== AW'(17'h10 + c - 1)) begin
          fails++;
          $display("FAIL basic_addr c=%0d got %h required %h", c, ob_addr, AW'(17'h10 + c - 1));
        end
      end
      next_cycle();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_left %0d words undelivered required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) launch(AW'(17'h10), AW'(8));
      else start = 1'b0;
      m_ready = (c >= 11);
      @(negedge CLK);
      if (c < 11 && ob_cen === 1'b0) begin
        tests++;
        if (ob_addr !== AW'(17'h10 + n)) begin
          fails++;
          $display("FAIL bp_addr c=%0d got %h required %h", c, ob_addr, AW'(17'h10 + n));
        end
        n++;
      end
      if (c == 11) begin
        tests++;
        if (n != 4) begin
          fails++;
          $display("FAIL bp_issued got %0d reads before release required 4", n);
        end
      end
      if (c >= 3 && c <= 10) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== DW'(17'h10)) begin
          fails++;
          $display("FAIL bp_hold c=%0d valid=%b data=%h required 1/10", c, m_valid, m_data[31:0]);
        end
      end
      tests++;
      if (done !== (c == 19)) begin
        fails++;
        $display("FAIL bp_done c=%0d got %b required %b", c, done, (c == 19));
      end
      next_cycle();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_left %0d words undelivered required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wa [4];
    wa[0] = 17'h1FFFE; wa[1] = 17'h1FFFF; wa[2] = 17'h00000; wa[3] = 17'h00001;
    m_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) launch(AW'(17'h1FFFE), AW'(4));
      else start = 1'b0;
      @(negedge CLK);
      if (c >= 1 && c <= 4) begin
        tests++;
        if (ob_cen !== 1'b0 || ob_addr !== wa[c-1]) begin
          fails++;
          $display("FAIL wrap_addr c=%0d cen=%b addr=%h required 0/%h", c, ob_cen, ob_addr, wa[c-1]);
        end
      end
      tests++;
      if (done !== (c == 7)) begin
        fails++;
        $display("FAIL wrap_done c=%0d got %b required %b", c, done, (c == 7));
      end
      next_cycle();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_left %0d words undelivered required 0", exp_q.size());
    end
  endtask

  task automatic test_corner();
    m_ready = 1'b1;
    // Zero-length command.
    for (int c = 0; c < 4; c++) begin
      if (c == 0) launch(AW'(17'h30), AW'(0));
      else start = 1'b0;
      @(negedge CLK);
      tests++;
      if (done !== (c == 1) || busy !== 1'b0 || ob_cen !== 1'b1) begin
        fails++;
        $display("FAIL zero_len c=%0d done=%b busy=%b cen=%b required %b/0/1",
                 c, done, busy, ob_cen, (c == 1));
      end
      next_cycle();
    end
    // Start while busy is ignored. A start in the done cycle launches at once.
    for (int c = 0; c < 15; c++) begin
      logic e_cen;
      logic [AW-1:0] e_addr;
      if (c == 0) launch(AW'(17'h20), AW'(4));
      else if (c == 2) begin start = 1'b1; base_addr = AW'(17'h50); length = AW'(2); end
      else if (c == 7) launch(AW'(17'h60), AW'(2));
      else start = 1'b0;
      @(negedge CLK);
      e_cen = 1'b1; e_addr = '0;
      if (c >= 1 && c <= 4) begin e_cen = 1'b0; e_addr = AW'(17'h20 + c - 1); end
      if (c >= 8 && c <= 9) begin e_cen = 1'b0; e_addr = AW'(17'h60 + c - 8); end
      tests++;
      if (ob_cen !== e_cen || (!e_cen && ob_addr !== e_addr)) begin
        fails++;
        $display("FAIL corner_issue c=%0d cen=%b addr=%h required %b/%h", c, ob_cen, ob_addr, e_cen, e_addr);
      end
      tests++;
      if (done !== (c == 7 || c == 12) || busy !== ((c >= 1 && c <= 6) || (c >= 8 && c <= 11))) begin
        fails++;
        $display("FAIL corner_ctl c=%0d done=%b busy=%b", c, done, busy);
      end
      next_cycle();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL corner_left %0d words undelivered required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) launch(AW'(17'h100), AW'(8));
      else start = 1'b0;
      next_cycle();
    end
    RESET = 1'b1;
    @(negedge CLK);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || ob_cen !== 1'b1 || ob_addr !== '0 ||
        m_valid !== 1'b0 || m_data !== '0) begin
      fails++;
      $display("FAIL midrst_vals busy=%b done=%b cen=%b addr=%h valid=%b data=%h",
               busy, done, ob_cen, ob_addr, m_valid, m_data[31:0]);
    end
    exp_q.delete();
    next_cycle();
    next_cycle();
    RESET = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || ob_cen !== 1'b1 || m_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst_quiet c=%0d done=%b busy=%b cen=%b valid=%b required 0/0/1/0",
                 c, done, busy, ob_cen, m_valid);
      end
      next_cycle();
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 0) launch(AW'(17'h200), AW'(3));
      else start = 1'b0;
      @(negedge CLK);
      if (c >= 1 && c <= 3) begin
        tests++;
        if (ob_cen !== 1'b0 || ob_addr !== AW'(17'h200 + c - 1)) begin
          fails++;
          $display("FAIL midrst_addr c=%0d cen=%b addr=%h required 0/%h",
                   c, ob_cen, ob_addr, AW'(17'h200 + c - 1));
        end
      end
      tests++;
      if (done !== (c == 6)) begin
        fails++;
        $display("FAIL midrst_done c=%0d got %b required %b", c, done, (c == 6));
      end
      next_cycle();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL midrst_left %0d words undelivered required 0", exp_q.size());
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    next_cycle();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_corner();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
